// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity encodings,
// FSM state type and the default 100 MHz / 9600 baud divisor.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_t;

  // Zero-extension to 9 bits leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [8:0] word, input int mode);
    return (mode == PAR_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous FIFO with registered read data; the head word is always
// presented on rd_data, so a pop consumes the value visible that cycle.
module uart_tx_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == DEPTH_CNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = rd_data_reg;

  assign push_ok     = push && !full;
  assign pop_ok      = pop && !empty;
  assign rd_ptr_next = pop_ok ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= wr_data;
  end

  // Prefetch the next head; forward the incoming word when it lands on that slot.
  always_ff @(posedge clk) begin
    if (push_ok && (wr_ptr_reg == rd_ptr_next))
      rd_data_reg <= wr_data;
    else
      rd_data_reg <= mem[rd_ptr_next];
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: configurable data width, parity and stop bits,
// back-to-back frames drained from a small input FIFO.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_send,
  input  logic                 transmit,
  output logic                 ready,
  output logic                 Txd,
  output logic                 busy,
  output logic                 Done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            state_reg, state_next;
  logic [BAUD_W-1:0]    baud_reg, baud_next;
  logic [3:0]           bit_reg, bit_next;
  logic                 stop_reg, stop_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 txd_reg, txd_next;
  logic                 run_reg;
  logic                 baud_last;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic [CNT_W-1:0]     fifo_count;

  // run_reg keeps ready low while reset is held.
  assign ready     = run_reg && !fifo_full;
  assign fifo_push = transmit && ready;
  assign baud_last = (baud_reg == BAUD_LAST);

  assign Txd  = txd_reg;
  assign busy = (state_reg != ST_IDLE) || (fifo_count != '0);
  assign Done = (state_reg == ST_STOP) && baud_last && (stop_reg == STOP_LAST);

  uart_tx_fifo_buf #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (data_send),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      stop_reg  <= 1'b0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      txd_reg   <= 1'b1;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      stop_reg  <= stop_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      txd_reg   <= txd_next;
      run_reg   <= 1'b1;
    end
  end

  // txd_next is the line level for the cycle following each edge.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_last ? '0 : baud_reg + BAUD_W'(1);
    bit_next   = bit_reg;
    stop_next  = stop_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    txd_next   = txd_reg;
    fifo_pop   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        baud_next = '0;
        txd_next  = 1'b1;
        if (!fifo_empty)
          fifo_pop = 1'b1;
      end
      ST_START: begin
        if (baud_last) begin
          state_next = ST_DATA;
          bit_next   = '0;
          txd_next   = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          if (bit_reg == BIT_LAST) begin
            if (PARITY != PAR_NONE) begin
              state_next = ST_PAR;
              txd_next   = par_reg;
            end else begin
              state_next = ST_STOP;
              stop_next  = 1'b0;
              txd_next   = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + 4'd1;
            shift_next = shift_reg >> 1;
            txd_next   = shift_reg[1];
          end
        end
      end
      ST_PAR: begin
        if (baud_last) begin
          state_next = ST_STOP;
          stop_next  = 1'b0;
          txd_next   = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          if (stop_reg != STOP_LAST) begin
            stop_next = stop_reg + 1'b1;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
          end else begin
            state_next = ST_IDLE;
            txd_next   = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        txd_next   = 1'b1;
      end
    endcase

    // A pop from IDLE or from the last stop cycle starts the next frame at once.
    if (fifo_pop) begin
      state_next = ST_START;
      baud_next  = '0;
      shift_next = fifo_rd_data;
      par_next   = parity_bit(9'(fifo_rd_data), PARITY);
      txd_next   = 1'b0;
    end
  end

endmodule
